axi_read_arbiter: RTL and testbench
===================================

Name: axi_read_arbiter

Overview:
- Sequential replacement for the combinational inst/data read merge.
- Owns the single AXI AR/R channel pair.
- Arbitrates instruction-cache and data-cache read requests (cached line refill or uncached single word), issues one AR per grant, and routes R beats to the granted requester with a word index.
- Holds the grant from AR handshake through RLAST; exactly one read transaction outstanding.

Parameters:
- LINE_WORDS, 16, beats per cached refill (arlen = LINE_WORDS-1); power of two, max 16.
- INST_ID, 4'd0, ARID used for instruction requests.
- DATA_ID, 4'd1, ARID used for data requests.
- FAIR, 1, 1 = alternate grant under contention; 0 = data always wins.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- inst_req  in  1  instruction read request, held until inst_ack
- inst_addr  in  32  start address (line-aligned when cached)
- inst_cached  in  1  1 = LINE_WORDS INCR burst, 0 = single beat
- inst_ack  out  1  one-cycle pulse on AR handshake for inst
- inst_rvalid  out  1  beat valid for inst
- inst_rdata  out  32  beat data
- inst_rlast  out  1  final beat
- inst_beat  out  4  word index of current beat
- data_req, data_addr, data_cached, data_ack, data_rvalid, data_rdata, data_rlast, data_beat: same as inst_* for the data side
- busy  out  1  state != IDLE
- err  out  1  one-cycle pulse with the final beat if the burst was anomalous
- arid  out  4,  araddr  out  32,  arlen  out  8,  arsize  out  3,  arburst  out  2,  arlock  out  2,  arcache  out  4,  arprot  out  3,  arvalid  out  1,  arready  in  1
- rid  in  4,  rdata  in  32,  rresp  in  2,  rlast  in  1,  rvalid  in  1,  rready  out  1

Behaviour:
- Clock and reset: one clock `clk`. `rst` is synchronous and active-high.
- Reset values:
  - state = IDLE; arvalid = 0; rready = 0.
  - All *_ack, *_rvalid, *_rlast, err, busy = 0.
  - Beat counter = 0; last_grant = INST, so the first contended grant goes to data.
- States: IDLE, ADDR, DATA.
- IDLE:
  - If only one request is present, grant it.
  - If both are present:
    - FAIR=0: grant data.
    - FAIR=1: grant data unless last_grant == DATA, then grant inst.
  - On grant, register the AR fields:
    - araddr = granted addr.
    - arlen = cached ? LINE_WORDS-1 : 0.
    - arburst = cached ? INCR(01) : FIXED(00).
    - arid = granted ID.
  - Update last_grant and clear the anomaly flag.
  - Next state ADDR: arvalid rises the cycle after req is sampled (1-cycle latency).
- ADDR:
  - arvalid = 1; AR fields stable until handshake.
  - On arvalid & arready: pulse the granted *_ack in that cycle, clear the beat counter, next state DATA.
  - A requester dropping req in ADDR does not withdraw arvalid (AXI rule); the transaction completes and its beats are still delivered.
- DATA:
  - rready = 1 (combinational on state).
  - On rvalid, forward combinationally to the granted side only: *_rvalid = rvalid, *_rdata = rdata, *_rlast = rlast, *_beat = beat counter.
  - Ungranted side: rvalid and rlast = 0; its rdata holds the last value.
  - The counter increments per beat, saturating at arlen.
  - On rvalid & rlast, next state IDLE. Minimum gap from RLAST to the next arvalid is 2 cycles.
- Constant outputs: arsize = 3'b010, arlock = 0, arcache = 0, arprot = 0.
- Anomaly flag is set if any of the following occurs during the burst:
  - rresp != 0;
  - rid != granted ID;
  - rlast with beat != arlen;
  - rvalid after the beat reached arlen without rlast.
  - err = flag | current-beat anomaly, pulsed with the rlast beat.
  - Beats are still forwarded; the FSM waits for rlast regardless.
- Other rules:
  - R beats arriving outside DATA are ignored (rready = 0).
  - Reset mid-transaction abandons it immediately (interconnect shares the reset); no ack or last is generated.
  - A new request is never sampled in the same cycle as RLAST.

Decomposition:
- Shared package `axi_pkg`:
  - FSM state encoding.
  - Grant enum INST/DATA.
  - ARSIZE_WORD, BURST_FIXED, BURST_INCR.
  - Default INST_ID/DATA_ID.
- No sub-module: the FSM, beat counter and mux fit in one file.

Test Plan:
- inst_req=1, inst_addr=0x1fc0_0000, inst_cached=1, arready immediate, 16 beats 0..15 with rlast on beat 15 -> arvalid at cycle+1, arlen=0x0f, arburst=01, arid=0; inst_beat 0..15; inst_rlast only on beat 15; inst_ack one pulse; err=0.
- data_req uncached addr 0xbfaf_8000, arready delayed 3 cycles -> arvalid and araddr stable 4 cycles; arlen=0, arburst=00, arid=1; one data_rvalid with data_rlast.
- Both reqs asserted in the same cycle three times, FAIR=1 -> grant order data, inst, data. With FAIR=0 -> data, data, data until data_req drops.
- Burst with rlast on beat 10 of 16 -> err pulse on beat 10, FSM to IDLE. Separately, rresp=2'b10 on beat 3 -> err with rlast only.
- rst asserted at beat 5 of a burst -> next cycle arvalid=0, rready=0, busy=0, no *_rlast. A fresh inst request then completes normally.
- RLAST at cycle t with data_req held -> arvalid reasserted at t+2; inst side sees no rvalid during the data burst.

Source files
------------

// File: rtl/axi_pkg.sv
// Shared AXI read-side definitions: FSM encoding, grant owner, AR field codes.
// Pure types and constants; no logic, no latency, no backpressure.
package axi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  typedef enum logic {
    GNT_INST = 1'b0,
    GNT_DATA = 1'b1
  } grant_t;

  localparam logic [2:0] ARSIZE_WORD = 3'b010;
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;

  localparam logic [3:0] DEF_INST_ID = 4'd0;
  localparam logic [3:0] DEF_DATA_ID = 4'd1;

endpackage

// File: rtl/axi_read_arbiter.sv
// Inst/data read arbiter owning one AXI AR/R pair; arvalid one cycle after req, R beats routed combinationally.
// One transaction outstanding; AR waits on arready, R is accepted every cycle of DATA (rready = state==DATA).
module axi_read_arbiter
  import axi_pkg::*;
#(
  parameter int         LINE_WORDS = 16,
  parameter logic [3:0] INST_ID    = DEF_INST_ID,
  parameter logic [3:0] DATA_ID    = DEF_DATA_ID,
  parameter bit         FAIR       = 1'b1
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  input  logic        inst_cached,
  output logic        inst_ack,
  output logic        inst_rvalid,
  output logic [31:0] inst_rdata,
  output logic        inst_rlast,
  output logic [3:0]  inst_beat,

  input  logic        data_req,
  input  logic [31:0] data_addr,
  input  logic        data_cached,
  output logic        data_ack,
  output logic        data_rvalid,
  output logic [31:0] data_rdata,
  output logic        data_rlast,
  output logic [3:0]  data_beat,

  output logic        busy,
  output logic        err,

  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,

  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready
);

  localparam logic [7:0] LINE_LEN = 8'(LINE_WORDS - 1);

  state_t      state;
  grant_t      grant;
  grant_t      last_grant;
  logic [3:0]  beat;
  logic        anom;
  logic [31:0] inst_rdata_q;
  logic [31:0] data_rdata_q;

  logic        pick_data;
  logic        sel_cached;
  logic [31:0] sel_addr;
  logic        in_data;
  logic        beat_fire;
  logic        last_beat;
  logic        cur_anom;

  // Under contention FAIR alternates; otherwise data wins outright.
  assign pick_data  = data_req && (!inst_req || !FAIR || (last_grant != GNT_DATA));
  assign sel_cached = pick_data ? data_cached : inst_cached;
  assign sel_addr   = pick_data ? data_addr : inst_addr;

  assign in_data   = (state == ST_DATA);
  assign beat_fire = in_data && rvalid;
  assign last_beat = (beat == arlen[3:0]);
  assign cur_anom  = (rresp != 2'b00) || (rid != arid) ||
                     (rlast && !last_beat) || (!rlast && last_beat);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      grant        <= GNT_INST;
      last_grant   <= GNT_INST;
      arvalid      <= 1'b0;
      arid         <= INST_ID;
      araddr       <= 32'd0;
      arlen        <= 8'd0;
      arburst      <= BURST_FIXED;
      beat         <= 4'd0;
      anom         <= 1'b0;
      inst_rdata_q <= 32'd0;
      data_rdata_q <= 32'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (inst_req || data_req) begin
            grant      <= pick_data ? GNT_DATA : GNT_INST;
            last_grant <= pick_data ? GNT_DATA : GNT_INST;
            arid       <= pick_data ? DATA_ID : INST_ID;
            araddr     <= sel_addr;
            arlen      <= sel_cached ? LINE_LEN : 8'd0;
            arburst    <= sel_cached ? BURST_INCR : BURST_FIXED;
            anom       <= 1'b0;
            arvalid    <= 1'b1;
            state      <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (arready) begin
            arvalid <= 1'b0;
            beat    <= 4'd0;
            state   <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (rvalid) begin
            // Saturate so an overlong burst keeps reporting the final index.
            beat <= last_beat ? beat : beat + 4'd1;
            anom <= anom | cur_anom;
            if (grant == GNT_INST) inst_rdata_q <= rdata;
            else                   data_rdata_q <= rdata;
            if (rlast) state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy   = (state != ST_IDLE);
  assign rready = in_data;

  assign inst_ack = (state == ST_ADDR) && arready && (grant == GNT_INST);
  assign data_ack = (state == ST_ADDR) && arready && (grant == GNT_DATA);

  assign inst_rvalid = beat_fire && (grant == GNT_INST);
  assign data_rvalid = beat_fire && (grant == GNT_DATA);
  assign inst_rlast  = inst_rvalid && rlast;
  assign data_rlast  = data_rvalid && rlast;
  assign inst_rdata  = inst_rvalid ? rdata : inst_rdata_q;
  assign data_rdata  = data_rvalid ? rdata : data_rdata_q;
  assign inst_beat   = (grant == GNT_INST) ? beat : 4'd0;
  assign data_beat   = (grant == GNT_DATA) ? beat : 4'd0;

  assign err = beat_fire && rlast && (anom || cur_anom);

  assign arsize  = ARSIZE_WORD;
  assign arlock  = 2'b00;
  assign arcache = 4'b0000;
  assign arprot  = 3'b000;

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Scoreboard bench: a fair and a data-priority arbiter share one stimulus stream;
// expected AR requests and R beats are queued at drive time and popped by a negedge monitor.
module tb_axi_read_arbiter;
  import axi_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        inst_req, inst_cached, data_req, data_cached;
  logic [31:0] inst_addr, data_addr;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast, rvalid;

  logic        f_inst_ack, f_inst_rvalid, f_inst_rlast, f_data_ack, f_data_rvalid, f_data_rlast;
  logic [31:0] f_inst_rdata, f_data_rdata, f_araddr;
  logic [3:0]  f_inst_beat, f_data_beat, f_arid, f_arcache;
  logic        f_busy, f_err, f_arvalid, f_rready;
  logic [7:0]  f_arlen;
  logic [2:0]  f_arsize, f_arprot;
  logic [1:0]  f_arburst, f_arlock;

  logic        p_inst_ack, p_inst_rvalid, p_inst_rlast, p_data_ack, p_data_rvalid, p_data_rlast;
  logic [31:0] p_inst_rdata, p_data_rdata, p_araddr;
  logic [3:0]  p_inst_beat, p_data_beat, p_arid, p_arcache;
  logic        p_busy, p_err, p_arvalid, p_rready;
  logic [7:0]  p_arlen;
  logic [2:0]  p_arsize, p_arprot;
  logic [1:0]  p_arburst, p_arlock;

  axi_read_arbiter #(.LINE_WORDS(16), .INST_ID(4'd0), .DATA_ID(4'd1), .FAIR(1'b1)) u_fair (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_cached(inst_cached), .inst_ack(f_inst_ack),
    .inst_rvalid(f_inst_rvalid), .inst_rdata(f_inst_rdata), .inst_rlast(f_inst_rlast), .inst_beat(f_inst_beat),
    .data_req(data_req), .data_addr(data_addr), .data_cached(data_cached), .data_ack(f_data_ack),
    .data_rvalid(f_data_rvalid), .data_rdata(f_data_rdata), .data_rlast(f_data_rlast), .data_beat(f_data_beat),
    .busy(f_busy), .err(f_err),
    .arid(f_arid), .araddr(f_araddr), .arlen(f_arlen), .arsize(f_arsize), .arburst(f_arburst),
    .arlock(f_arlock), .arcache(f_arcache), .arprot(f_arprot), .arvalid(f_arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(f_rready)
  );

  axi_read_arbiter #(.LINE_WORDS(16), .INST_ID(4'd0), .DATA_ID(4'd1), .FAIR(1'b0)) u_prio (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_cached(inst_cached), .inst_ack(p_inst_ack),
    .inst_rvalid(p_inst_rvalid), .inst_rdata(p_inst_rdata), .inst_rlast(p_inst_rlast), .inst_beat(p_inst_beat),
    .data_req(data_req), .data_addr(data_addr), .data_cached(data_cached), .data_ack(p_data_ack),
    .data_rvalid(p_data_rvalid), .data_rdata(p_data_rdata), .data_rlast(p_data_rlast), .data_beat(p_data_beat),
    .busy(p_busy), .err(p_err),
    .arid(p_arid), .araddr(p_araddr), .arlen(p_arlen), .arsize(p_arsize), .arburst(p_arburst),
    .arlock(p_arlock), .arcache(p_arcache), .arprot(p_arprot), .arvalid(p_arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(p_rready)
  );

  typedef struct packed {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [1:0]  burst;
  } ar_t;

  typedef struct packed {
    logic        side;   // 1 = data
    logic [3:0]  beat;
    logic [31:0] data;
    logic        last;
    logic        err;
  } bt_t;

  ar_t exp_ar_f[$];
  ar_t exp_ar_p[$];
  bt_t exp_bt[$];

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
  endtask

  function automatic ar_t mk_ar(input logic is_data, input logic [31:0] a, input logic cached);
    ar_t r;
    r.id    = is_data ? 4'd1 : 4'd0;
    r.addr  = a;
    r.len   = cached ? 8'h0f : 8'h00;
    r.burst = cached ? 2'b01 : 2'b00;
    return r;
  endfunction

  // Monitor
  int   cyc = 0;
  int   last_cyc = 0;
  bit   mon_en = 1'b0;
  bit   gap_arm = 1'b0;
  logic f_arv_q = 1'b0;
  ar_t  m_ar;
  bt_t  m_exp, m_obs;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mon_en) begin
      if (f_arvalid && arready) begin
        if (exp_ar_f.size() == 0) check("ar_f_unexpected", 1, 0);
        else begin
          m_ar = exp_ar_f.pop_front();
          check("ar_f", {f_arid, f_araddr, f_arlen, f_arburst}, m_ar);
          check("ack_f", {f_inst_ack, f_data_ack}, (m_ar.id == 4'd1) ? 2'b01 : 2'b10);
          check("ar_const", {f_arsize, f_arlock, f_arcache, f_arprot}, {3'b010, 2'b00, 4'h0, 3'b000});
        end
      end else if (f_inst_ack || f_data_ack) check("ack_f_stray", {f_inst_ack, f_data_ack}, 0);

      if (p_arvalid && arready) begin
        if (exp_ar_p.size() == 0) check("ar_p_unexpected", 1, 0);
        else begin
          m_ar = exp_ar_p.pop_front();
          check("ar_p", {p_arid, p_araddr, p_arlen, p_arburst}, m_ar);
          check("ack_p", {p_inst_ack, p_data_ack}, (m_ar.id == 4'd1) ? 2'b01 : 2'b10);
        end
      end

      if (f_arvalid && !f_arv_q && gap_arm) begin
        check("rlast_to_arvalid", 64'(cyc - last_cyc), 2);
        gap_arm = 1'b0;
      end
      f_arv_q = f_arvalid;

      if (f_inst_rvalid || f_data_rvalid) begin
        m_obs.side = f_data_rvalid;
        m_obs.beat = f_data_rvalid ? f_data_beat : f_inst_beat;
        m_obs.data = f_data_rvalid ? f_data_rdata : f_inst_rdata;
        m_obs.last = f_inst_rlast | f_data_rlast;
        m_obs.err  = f_err;
        if (m_obs.last) last_cyc = cyc;
        if (exp_bt.size() == 0) check("beat_unexpected", {f_inst_rvalid, f_data_rvalid}, 0);
        else begin
          m_exp = exp_bt.pop_front();
          check("beat", m_obs, m_exp);
          check("one_side", f_inst_rvalid & f_data_rvalid, 0);
        end
      end else if (f_err || f_inst_rlast || f_data_rlast)
        check("stray_last_err", {f_err, f_inst_rlast, f_data_rlast}, 0);
    end
  end

  // Waits for arvalid, holds arready low for d cycles checking AR stability, then handshakes.
  task automatic ar_phase(input int d, input logic [31:0] addr, output int waited);
    waited = -1;
    for (int t = 0; t < 50; t++) begin
      @(posedge clk); #1;
      if (f_arvalid) begin
        waited = t;
        break;
      end
    end
    if (waited < 0) begin
      check("ar_timeout", 0, 1);
      return;
    end
    for (int k = 0; k < d; k++) begin
      check("ar_hold", {f_arvalid, f_araddr}, {1'b1, addr});
      @(posedge clk); #1;
    end
    arready = 1'b1;
    @(posedge clk); #1;
    arready = 1'b0;
  endtask

  task automatic r_burst(input logic side, input logic [3:0] id, input int n, input int len,
                         input int last_at, input int resp_at, input logic [31:0] base);
    logic anom;
    int   idx;
    bt_t  b;
    anom = 1'b0;
    for (int i = 0; i < n; i++) begin
      idx    = (i > len) ? len : i;
      rvalid = 1'b1;
      rid    = id;
      rdata  = 32'(base + i);
      rlast  = (i == last_at);
      rresp  = (i == resp_at) ? 2'b10 : 2'b00;
      anom   = anom | (i == resp_at) | (rlast && idx != len) | (!rlast && idx == len);
      b.side = side;
      b.beat = 4'(idx);
      b.data = 32'(base + i);
      b.last = rlast;
      b.err  = rlast & anom;
      exp_bt.push_back(b);
      @(posedge clk); #1;
    end
    rvalid = 1'b0;
    rlast  = 1'b0;
    rresp  = 2'b00;
  endtask

  task automatic push_ar(input logic f_data, input logic p_data, input logic cached);
    exp_ar_f.push_back(mk_ar(f_data, f_data ? data_addr : inst_addr, cached));
    exp_ar_p.push_back(mk_ar(p_data, p_data ? data_addr : inst_addr, cached));
  endtask

  initial begin
    int w;
    logic fd, pd;
    rst = 1'b1; inst_req = 0; inst_addr = 0; inst_cached = 0;
    data_req = 0; data_addr = 0; data_cached = 0; arready = 0;
    rid = 0; rdata = 0; rresp = 0; rlast = 0; rvalid = 0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_f", {f_arvalid, f_rready, f_busy, f_err, f_inst_ack, f_data_ack,
                      f_inst_rvalid, f_data_rvalid, f_inst_rlast, f_data_rlast}, 0);
    check("reset_p", {p_arvalid, p_rready, p_busy, p_err}, 0);
    rst = 1'b0;
    mon_en = 1'b1;

    // Cached instruction refill, arready immediate
    @(posedge clk); #1;
    inst_req = 1; inst_addr = 32'h1fc0_0000; inst_cached = 1;
    push_ar(0, 0, 1);
    check("arvalid_before_sample", f_arvalid, 0);
    ar_phase(0, inst_addr, w);
    check("ar_latency", w, 0);
    inst_req = 0;
    check("busy_in_data", {f_busy, f_rready}, 2'b11);
    r_burst(0, 4'd0, 16, 15, 15, -1, 32'hA000_0000);

    // Contention: fair gives data,inst,data then inst; priority gives data x3 then inst
    @(posedge clk); #1;
    inst_req = 1; inst_addr = 32'h0000_4000; inst_cached = 0;
    data_req = 1; data_addr = 32'h0000_8000; data_cached = 0;
    for (int r = 0; r < 4; r++) begin
      fd = (r == 0 || r == 2);
      pd = (r < 3);
      push_ar(fd, pd, 0);
      ar_phase(0, 32'h0, w);
      if (r == 2) data_req = 0;
      if (r == 3) inst_req = 0;
      r_burst(fd, fd ? 4'd1 : 4'd0, 1, 0, 0, -1, 32'hC000_0000 + 32'(r));
    end

    // Uncached data read with arready held off 3 cycles
    @(posedge clk); #1;
    data_req = 1; data_addr = 32'hbfaf_8000; data_cached = 0;
    push_ar(1, 1, 0);
    ar_phase(3, data_addr, w);
    check("ar_latency_data", w, 0);
    data_req = 0;
    r_burst(1, 4'd1, 1, 0, 0, -1, 32'h1234_5678);

    // Early rlast on beat 10 of a 16-beat refill
    @(posedge clk); #1;
    data_req = 1; data_addr = 32'h0001_0000; data_cached = 1;
    push_ar(1, 1, 1);
    ar_phase(1, data_addr, w);
    data_req = 0;
    r_burst(1, 4'd1, 11, 15, 10, -1, 32'hD000_0000);
    check("idle_after_early_last", f_busy, 0);

    // Error response mid-burst reported only with rlast
    @(posedge clk); #1;
    inst_req = 1; inst_addr = 32'h0002_0040; inst_cached = 1;
    push_ar(0, 0, 1);
    ar_phase(2, inst_addr, w);
    inst_req = 0;
    r_burst(0, 4'd0, 16, 15, 15, 3, 32'hE000_0000);

    // Back-to-back data requests: arvalid returns two cycles after rlast
    @(posedge clk); #1;
    data_req = 1; data_addr = 32'h0003_0000; data_cached = 0;
    push_ar(1, 1, 0);
    ar_phase(0, data_addr, w);
    gap_arm = 1'b1;
    r_burst(1, 4'd1, 1, 0, 0, -1, 32'hF000_0000);
    push_ar(1, 1, 0);
    ar_phase(0, data_addr, w);
    data_req = 0;
    r_burst(1, 4'd1, 1, 0, 0, -1, 32'hF000_0001);
    check("gap_checked", gap_arm, 0);

    // Reset at beat 5 abandons the burst; leftover beats must not leak out
    @(posedge clk); #1;
    inst_req = 1; inst_addr = 32'h0004_0000; inst_cached = 1;
    push_ar(0, 0, 1);
    ar_phase(0, inst_addr, w);
    inst_req = 0;
    r_burst(0, 4'd0, 5, 15, -1, -1, 32'h5000_0000);
    rvalid = 1; rid = 0; rdata = 32'h5000_0005; rlast = 0; rst = 1;
    exp_bt.push_back('{1'b0, 4'd5, 32'h5000_0005, 1'b0, 1'b0});
    @(posedge clk); #1;
    rst = 0;
    check("rst_abort", {f_arvalid, f_rready, f_busy, p_arvalid, p_rready, p_busy}, 0);
    for (int i = 6; i < 16; i++) begin
      rdata = 32'h5000_0000 + 32'(i);
      rlast = (i == 15);
      @(posedge clk); #1;
    end
    rvalid = 0; rlast = 0;

    // Fresh instruction request after reset
    inst_req = 1; inst_addr = 32'h1fc0_0400; inst_cached = 1;
    push_ar(0, 0, 1);
    ar_phase(0, inst_addr, w);
    check("ar_latency_after_rst", w, 0);
    inst_req = 0;
    r_burst(0, 4'd0, 16, 15, 15, -1, 32'h6000_0000);

    repeat (4) @(posedge clk);
    #1;
    check("ar_f_left", exp_ar_f.size(), 0);
    check("ar_p_left", exp_ar_p.size(), 0);
    check("beats_left", exp_bt.size(), 0);
    check("idle_at_end", {f_busy, p_busy}, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
